// File: rtl/instruction_prefetch_unit_if.sv
// Prefetch unit bus bundle: instruction-memory request/acknowledge port,
// decode-side queue head with pop handshake, and redirect/exception controls.
//   mem_req/mem_addr      -> memory   : read request, address held until mem_ack
//   mem_ack/mem_rdata     <- memory   : data return strobe and instruction word
//   instr_valid/instr/instr_pc -> decode : prefetch queue head
//   instr_ready           <- decode   : pop the head
//   redirect/redirect_addr/exc <- control : fetch retarget and exception entry
//   epc_out/fetch_pc      -> control  : exception PC and next fetch address
interface instruction_prefetch_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = 32
);
  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_ack;
  logic [INSTR_WIDTH-1:0]   mem_rdata;
  logic                     instr_valid;
  logic [INSTR_WIDTH-1:0]   instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic                     instr_ready;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirect_addr;
  logic                     exc;
  logic [ADDRESS_WIDTH-1:0] epc_out;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;

  // Prefetch unit side
  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, epc_out, fetch_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_addr, exc
  );

  // Memory / decode / control side
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, epc_out, fetch_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_addr, exc
  );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: fetches ahead of decode into a circular queue of
// {pc, instruction} entries using a single-outstanding request/ack memory port.
// Redirect and exception flush the queue; an in-flight request is never
// withdrawn, its data is discarded on return instead.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - instruction_prefetch_unit_if.master (memory, decode, control signals)
module instruction_prefetch_unit #(
  parameter int unsigned            ADDRESS_WIDTH = 32,
  parameter int unsigned            INSTR_WIDTH   = 32,
  parameter int unsigned            QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDR  = ADDRESS_WIDTH'(32'h0040_0000),
  parameter logic [ADDRESS_WIDTH-1:0] EXC_VECTOR  = ADDRESS_WIDTH'(32'h8000_0180)
) (
  input logic                     clk,
  input logic                     rst,
  instruction_prefetch_unit_if.master bus
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                     flush;
  logic                     valid;
  logic                     pop;
  logic                     room_run;
  logic                     room_ack;
  logic [CNT_W-1:0]         count_after;
  logic                     issue_c;
  logic                     push_c;

  logic [CNT_W-1:0]         count_q;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [ADDRESS_WIDTH-1:0] pc_q   [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0]   data_q [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [ADDRESS_WIDTH-1:0] epc_q;
  logic                     mem_req_q;

  // Queue occupancy and flush/pop qualification
  assign flush       = bus.redirect | bus.exc;
  assign valid       = (count_q != '0);
  assign pop         = valid & bus.instr_ready & ~flush;
  assign room_run    = (count_q < DEPTH_C);
  // Occupancy after this cycle's push and pop, used to chain the next request
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);
  assign room_ack    = (count_after < DEPTH_C);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (room_run && !flush) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_ack)  state_nxt = (!flush && room_ack) ? S_WAIT : S_RUN;
        else if (flush)   state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (bus.mem_ack)  state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Output decode: request issue and queue push strobes
  always_comb begin
    issue_c = 1'b0;
    push_c  = 1'b0;
    case (state)
      S_RUN: begin
        issue_c = room_run & ~flush;
      end
      S_WAIT: begin
        if (bus.mem_ack && !flush) begin
          push_c  = 1'b1;
          issue_c = room_ack;
        end
      end
      default: ;
    endcase
  end

  // Fetch address, EPC and prefetch queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= START_ADDR;
      epc_q      <= '0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      mem_req_q <= (state_nxt != S_RUN);
      if (issue_c) mem_addr_q <= fetch_pc_q;

      if (bus.exc)           fetch_pc_q <= EXC_VECTOR;
      else if (bus.redirect) fetch_pc_q <= bus.redirect_addr & ~ADDRESS_WIDTH'(3);
      else if (issue_c)      fetch_pc_q <= fetch_pc_q + ADDRESS_WIDTH'(4);

      // EPC is the instruction decode was about to see, else where fetch was headed
      if (bus.exc) epc_q <= valid ? pc_q[rd_ptr] : fetch_pc_q;

      if (flush) begin
        count_q <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (push_c) begin
          pc_q[wr_ptr]   <= mem_addr_q;
          data_q[wr_ptr] <= bus.mem_rdata;
          wr_ptr         <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop);
      end
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.epc_out     = epc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = data_q[rd_ptr];
  assign bus.instr_pc    = pc_q[rd_ptr];

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Testbench for instruction_prefetch_unit: memory responder model, scoreboards
// for acknowledged fetch addresses and decoded queue entries, directed checks
// for reset, redirect/discard, exception/EPC, address wrap and async reset.
module tb_instruction_prefetch_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_prefetch_unit_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  instruction_prefetch_unit #(
    .ADDRESS_WIDTH(AW),
    .INSTR_WIDTH  (IW),
    .QUEUE_DEPTH  (4),
    .START_ADDR   (32'h0040_0000),
    .EXC_VECTOR   (32'h8000_0180)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] mon_pc;

  bit          mem_en;
  int unsigned lat;
  int unsigned wait_cnt;
  bit          found;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks an outstanding request after lat cycles
  always @(posedge clk) begin
    #2;
    if (rst || !mem_en) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (bus.mem_req) begin
      if (wait_cnt >= lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_data(bus.mem_addr);
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: acknowledged fetch addresses and decode pops against scoreboards
  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack) begin
      if (exp_addr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_ack_addr: got %h expected no acknowledged request", bus.mem_addr);
      end else begin
        chk("mem_ack_addr", bus.mem_addr, exp_addr.pop_front());
      end
    end
    if (bus.instr_valid && bus.instr_ready) begin
      if (exp_pc.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL decode_pop: got pc %h expected no pop", bus.instr_pc);
      end else begin
        mon_pc = exp_pc.pop_front();
        chk("decode_pc", bus.instr_pc, mon_pc);
        chk("decode_instr", bus.instr, mem_data(mon_pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected end of sequence");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    mem_en            = 1'b0;
    lat               = 1;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.exc           = 1'b0;

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_mem_req",     32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr",    bus.mem_addr, 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr",       bus.instr, 32'h0);
    chk("rst_instr_pc",    bus.instr_pc, 32'h0);
    chk("rst_epc",         bus.epc_out, 32'h0);
    chk("rst_fetch_pc",    bus.fetch_pc, 32'h0040_0000);

    // Fill from START_ADDR with decode stalled
    exp_addr.push_back(32'h0040_0000);
    exp_addr.push_back(32'h0040_0004);
    exp_addr.push_back(32'h0040_0008);
    exp_addr.push_back(32'h0040_000C);
    mem_en = 1'b1;
    lat    = 1;
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("first_req",  32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'h0040_0000);
    repeat (20) tick();
    @(negedge clk);
    chk("full_no_req",   32'(bus.mem_req), 32'd0);
    chk("full_fetch_pc", bus.fetch_pc, 32'h0040_0010);
    chk("full_valid",    32'(bus.instr_valid), 32'd1);
    chk("full_head_pc",  bus.instr_pc, 32'h0040_0000);
    chk("full_head",     bus.instr, 32'h5A1A_0F0F);

    // One pop from a full queue refills exactly one entry
    exp_pc.push_back(32'h0040_0000);
    exp_addr.push_back(32'h0040_0010);
    tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("pop1_head_pc",  bus.instr_pc, 32'h0040_0004);
    chk("pop1_no_req",   32'(bus.mem_req), 32'd0);
    chk("pop1_fetch_pc", bus.fetch_pc, 32'h0040_0014);

    // Exception with simultaneous redirect: exception wins, EPC = head PC
    exp_addr.push_back(32'h8000_0180);
    exp_addr.push_back(32'h8000_0184);
    exp_addr.push_back(32'h8000_0188);
    exp_addr.push_back(32'h8000_018C);
    tick();
    bus.exc           = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h1234_5678;
    tick();
    bus.exc      = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("exc_epc",      bus.epc_out, 32'h0040_0004);
    chk("exc_fetch_pc", bus.fetch_pc, 32'h8000_0180);
    chk("exc_flushed",  32'(bus.instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("exc_req",  32'(bus.mem_req), 32'd1);
    chk("exc_addr", bus.mem_addr, 32'h8000_0180);
    repeat (20) tick();

    // Redirect while a request is outstanding: returned data is discarded
    exp_addr.push_back(32'h0040_0008);
    exp_addr.push_back(32'h0040_0100);
    exp_addr.push_back(32'h0040_0104);
    exp_addr.push_back(32'h0040_0108);
    exp_addr.push_back(32'h0040_010C);
    tick();
    mem_en            = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0040_0008;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0040_0103;
    @(negedge clk);
    chk("inflight_req",  32'(bus.mem_req), 32'd1);
    chk("inflight_addr", bus.mem_addr, 32'h0040_0008);
    tick();
    bus.redirect = 1'b0;
    lat          = 3;
    mem_en       = 1'b1;
    @(negedge clk);
    chk("discard_req",      32'(bus.mem_req), 32'd1);
    chk("discard_addr",     bus.mem_addr, 32'h0040_0008);
    chk("discard_empty",    32'(bus.instr_valid), 32'd0);
    chk("discard_fetch_pc", bus.fetch_pc, 32'h0040_0100);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr != 32'h0040_0008) found = 1'b1;
    end
    chk("redir_reissue_seen", 32'(found), 32'd1);
    chk("redir_addr",         bus.mem_addr, 32'h0040_0100);
    chk("redir_not_pushed",   32'(bus.instr_valid), 32'd0);
    repeat (30) tick();
    exp_pc.push_back(32'h0040_0100);
    mem_en          = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("pre_rst_req",     32'(bus.mem_req), 32'd1);
    chk("pre_rst_addr",    bus.mem_addr, 32'h0040_0110);
    chk("pre_rst_head_pc", bus.instr_pc, 32'h0040_0104);

    // Asynchronous reset mid-request with three queued entries
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_req",     32'(bus.mem_req), 32'd0);
    chk("arst_mem_addr",    bus.mem_addr, 32'h0);
    chk("arst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_instr",       bus.instr, 32'h0);
    chk("arst_instr_pc",    bus.instr_pc, 32'h0);
    chk("arst_epc",         bus.epc_out, 32'h0);
    chk("arst_fetch_pc",    bus.fetch_pc, 32'h0040_0000);
    exp_addr.push_back(32'h0040_0000);
    exp_addr.push_back(32'h0040_0004);
    exp_addr.push_back(32'h0040_0008);
    exp_addr.push_back(32'h0040_000C);
    tick();
    tick();
    mem_en = 1'b1;
    lat    = 1;
    rst    = 1'b0;
    tick();
    @(negedge clk);
    chk("restart_req",  32'(bus.mem_req), 32'd1);
    chk("restart_addr", bus.mem_addr, 32'h0040_0000);
    repeat (20) tick();

    // Redirect to the top word: fetch PC wraps to zero
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    exp_addr.push_back(32'h0000_0004);
    exp_addr.push_back(32'h0000_0008);
    tick();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_addr",     bus.mem_addr, 32'hFFFF_FFFC);
    chk("wrap_fetch_pc", bus.fetch_pc, 32'h0000_0000);
    repeat (20) tick();
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0000_0000);
    mem_en          = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("wrap_head_pc", bus.instr_pc, 32'h0000_0004);
    chk("wrap_head",    bus.instr, 32'h5A5A_0F0B);

    // Every expected transaction was observed
    chk("addr_sb_drained",  32'(exp_addr.size()), 32'd0);
    chk("instr_sb_drained", 32'(exp_pc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_unit.md
Name: instruction_prefetch_unit

Overview:
- Parametrised successor to the multi-cycle fetch path.
- Decouples instruction fetch from decode with a prefetch queue of QUEUE_DEPTH {PC, instruction} entries.
- Fetch runs through a request/acknowledge memory handshake with one outstanding request.
- Supports redirect (branch/jump) with queue flush, exception vectoring and EPC capture; sits between the instruction memory port and the decode/control unit.

Parameters:
- ADDRESS_WIDTH, 32, width of all addresses and PCs.
- INSTR_WIDTH, 32, instruction word width.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2.
- START_ADDR, 32'h0040_0000, fetch PC after reset.
- EXC_VECTOR, 32'h8000_0180, fetch target on exception.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- MEM_REQ  out  1  memory read request.
- MEM_ADDR  out  ADDRESS_WIDTH  request address, word aligned.
- MEM_ACK  in  1  memory returns data this cycle.
- MEM_RDATA  in  INSTR_WIDTH  instruction data, valid with MEM_ACK.
- INSTR_VALID  out  1  queue head holds a valid entry.
- INSTR  out  INSTR_WIDTH  queue head instruction.
- INSTR_PC  out  ADDRESS_WIDTH  queue head PC.
- INSTR_READY  in  1  decode consumes the head (pop) when INSTR_VALID is high.
- REDIRECT  in  1  load a new fetch target.
- REDIRECT_ADDR  in  ADDRESS_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- EXC  in  1  exception; vector fetch and capture EPC.
- EPC_OUT  out  ADDRESS_WIDTH  exception PC register.
- FETCH_PC  out  ADDRESS_WIDTH  address of the next request to issue.

Behaviour:

Reset:
- State RUN, FETCH_PC = START_ADDR, queue empty (count 0).
- MEM_REQ = 0, MEM_ADDR = 0, INSTR_VALID = 0, INSTR = 0, INSTR_PC = 0, EPC_OUT = 0.
- Reset asserted mid-request abandons the request; the memory side must tolerate a REQ drop on reset only.

State machine (MEM_REQ = 1 in WAIT and DISCARD, registered; MEM_ADDR held stable until MEM_ACK):
- RUN (no request outstanding): if count < QUEUE_DEPTH and no REDIRECT/EXC, then MEM_ADDR <= FETCH_PC, FETCH_PC <= FETCH_PC+4, go to WAIT. MEM_ACK in RUN is ignored.
- WAIT, MEM_ACK: push {MEM_ADDR, MEM_RDATA}. If (count + 1 - pop) < QUEUE_DEPTH and no REDIRECT/EXC, issue the next address the same edge and stay in WAIT; otherwise go to RUN.
- WAIT, REDIRECT/EXC without MEM_ACK: go to DISCARD. MEM_REQ stays high; the in-flight request is never withdrawn.
- WAIT, REDIRECT/EXC with MEM_ACK: data dropped, go to RUN.
- DISCARD, MEM_ACK: data dropped, go to RUN. A further REDIRECT/EXC in DISCARD only updates FETCH_PC.

Redirect / exception:
- REDIRECT: queue flushed (count 0, INSTR_VALID 0 next cycle); FETCH_PC <= REDIRECT_ADDR & ~3.
- EXC: has priority over REDIRECT. FETCH_PC <= EXC_VECTOR; EPC_OUT <= INSTR_PC if INSTR_VALID, else FETCH_PC; queue flushed.
- A pop in the same cycle as a flush is ignored.

Queue:
- Circular buffer with read/write pointers modulo QUEUE_DEPTH and a count in 0..QUEUE_DEPTH.
- Push and pop in the same cycle leave count unchanged.
- Issue gating guarantees no push when full; pop when empty is ignored.
- INSTR, INSTR_PC and INSTR_VALID are driven from the head entry (registered storage).

Arithmetic and latency:
- PC increment is modulo 2^ADDRESS_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: MEM_ACK at edge t, entry visible at INSTR_VALID after edge t.
- First MEM_REQ is high in the first cycle after reset release, with MEM_ADDR = START_ADDR.

Test Plan:
- Reset release, memory ACKs every request the cycle after REQ, INSTR_READY = 0 -> addresses 0x00400000, 04, 08, 0C fetched. After 4 pushes MEM_REQ stays 0 and FETCH_PC = 0x00400010.
- Full queue with INSTR_READY = 1 for one cycle -> INSTR_PC advances to 0x00400004, next request 0x00400010 issued, count returns to 4.
- REDIRECT to 0x00400103 while a request to 0x00400008 is outstanding, ACK 3 cycles later -> returned data not pushed, queue empty, next MEM_ADDR = 0x00400100.
- EXC while head INSTR_PC = 0x00400004 and REDIRECT asserted simultaneously -> EPC_OUT = 0x00400004, next MEM_ADDR = 0x80000180, REDIRECT target ignored.
- REDIRECT to 0xFFFFFFFC -> fetch addresses 0xFFFFFFFC then 0x00000000.
- RST asserted while MEM_REQ = 1 and the queue holds 3 entries -> all outputs at reset values immediately (asynchronous); after release, fetch restarts at 0x00400000.
